// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields plus a signed immediate into a
// 32-bit instruction word through a two-stage valid/ready pipeline.
module instr_encoder #(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic               s1_valid;
  logic [6:0]         s1_opcode;
  logic [4:0]         s1_rd;
  logic [4:0]         s1_rs1;
  logic [4:0]         s1_rs2;
  logic [2:0]         s1_funct3;
  logic [6:0]         s1_funct7;
  logic signed [31:0] s1_imm;

  logic               s2_valid;
  logic               s2_ready;

  logic [31:0]        enc_word;
  logic               enc_bad;
  logic               fits_i;
  logic               fits_b;
  logic               fits_j;

  assign s2_ready  = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_ready;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_opcode <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_funct3 <= '0;
      s1_funct7 <= '0;
      s1_imm    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_opcode <= opcode;
        s1_rd     <= rd;
        s1_rs1    <= rs1;
        s1_rs2    <= rs2;
        s1_funct3 <= funct3;
        s1_funct7 <= funct7;
        s1_imm    <= imm;
      end
    end
  end

  // Range checks use the full signed 32-bit value so truncated immediates never pass.
  always_comb begin
    fits_i   = (s1_imm >= -32'sd2048)    && (s1_imm <= 32'sd2047);
    fits_b   = (s1_imm >= -32'sd4096)    && (s1_imm <= 32'sd4094)    && !s1_imm[0];
    fits_j   = (s1_imm >= -32'sd1048576) && (s1_imm <= 32'sd1048574) && !s1_imm[0];
    enc_word = '0;
    enc_bad  = 1'b0;
    case (s1_opcode)
      OP_IMM: begin
        if (s1_funct3 == 3'b001 || s1_funct3 == 3'b101) begin
          enc_word = {s1_funct7, s1_imm[4:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
          enc_bad  = (s1_imm < 32'sd0) || (s1_imm > 32'sd31);
        end else begin
          enc_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
          enc_bad  = !fits_i;
        end
      end
      OP_JALR, OP_LOAD: begin
        enc_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
        enc_bad  = !fits_i;
      end
      OP_STORE: begin
        enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
        enc_bad  = !fits_i;
      end
      OP_BRANCH: begin
        enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                    s1_imm[4:1], s1_imm[11], s1_opcode};
        enc_bad  = !fits_b;
      end
      OP_JAL: begin
        enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
        enc_bad  = !fits_j;
      end
      OP_LUI, OP_AUIPC: begin
        enc_word = {s1_imm[31:12], s1_rd, s1_opcode};
        enc_bad  = (s1_imm[11:0] != 12'h000);
      end
      OP_OP: begin
        enc_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      end
      default: enc_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= enc_bad ? NOP : enc_word;
        out_err   <= enc_bad;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (s2_valid && out_ready && out_err && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and constrained-random bench for instr_encoder; expected words are
// hand-computed and streamed words are checked with an independent decoder.
module tb_instr_encoder;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [3:0]  err_count;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_cnt = '0;

  instr_encoder #(.ERR_CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] r_d, r_s1, r_s2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    opcode = op; rd = r_d; rs1 = r_s1; rs2 = r_s2;
    funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  // One word through an idle pipeline with out_ready=1.
  task automatic send_one(input string tag, input logic [6:0] op, input logic [4:0] r_d, r_s1, r_s2,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                          input logic [31:0] exp_w, input logic exp_e);
    @(negedge clk);
    drive(op, r_d, r_s1, r_s2, f3, f7, im);
    #1 check({tag, "_in_ready"}, 64'(in_ready), 64'(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, 64'(out_valid), 64'(1'b0));
    @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
    check({tag, "_instr"}, 64'(out_instr), 64'(exp_w));
    check({tag, "_err"}, 64'(out_err), 64'(exp_e));
    if (exp_e && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    @(negedge clk);
    check({tag, "_err_count"}, 64'(err_count), 64'(exp_cnt));
    check({tag, "_drained"}, 64'(out_valid), 64'(1'b0));
  endtask

  // Packs {opcode, rd, rs1, rs2, funct3, funct7, imm}; fields a format does not use are zero.
  function automatic logic [63:0] decode(input logic [31:0] w);
    logic [6:0] op;
    logic [4:0] d, s1, s2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] iimm;
    op = w[6:0]; d = w[11:7]; f3 = w[14:12]; s1 = w[19:15]; s2 = w[24:20]; f7 = w[31:25];
    iimm = {{20{w[31]}}, w[31:20]};
    case (op)
      OP_IMM:
        if (f3 == 3'b001 || f3 == 3'b101) return {op, d, s1, 5'b0, f3, f7, {27'b0, w[24:20]}};
        else return {op, d, s1, 5'b0, f3, 7'b0, iimm};
      OP_LOAD, OP_JALR: return {op, d, s1, 5'b0, f3, 7'b0, iimm};
      OP_STORE:  return {op, 5'b0, s1, s2, f3, 7'b0, {{20{w[31]}}, w[31:25], w[11:7]}};
      OP_BRANCH: return {op, 5'b0, s1, s2, f3, 7'b0,
                         {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0}};
      OP_JAL:    return {op, d, 5'b0, 5'b0, 3'b0, 7'b0,
                         {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}};
      OP_LUI, OP_AUIPC: return {op, d, 5'b0, 5'b0, 3'b0, 7'b0, {w[31:12], 12'b0}};
      OP_OP:     return {op, d, s1, s2, f3, f7, 32'b0};
      default:   return '0;
    endcase
  endfunction

  // Random legal encoding; unused fields are driven with junk but zeroed in the expectation.
  task automatic gen_random(output logic [63:0] expv);
    logic [6:0] op, f7;
    logic [4:0] d, s1, s2;
    logic [2:0] f3;
    logic [31:0] im;
    int fmt;
    d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
    f3 = 3'($urandom); f7 = 7'($urandom); im = $urandom;
    fmt = int'($urandom_range(0, 8));
    case (fmt)
      0, 2, 3: begin
        op = (fmt == 0) ? OP_IMM : (fmt == 2) ? OP_LOAD : OP_JALR;
        if (fmt == 0 && f3 == 3'b001) f3 = 3'b111;
        if (fmt == 0 && f3 == 3'b101) f3 = 3'b110;
        if (fmt == 3) f3 = 3'b000;
        im = 32'(int'($urandom_range(0, 4095)) - 2048);
        expv = {op, d, s1, 5'b0, f3, 7'b0, im};
      end
      1: begin
        op = OP_IMM;
        f3 = ($urandom_range(0, 1) == 1) ? 3'b101 : 3'b001;
        f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        im = 32'($urandom_range(0, 31));
        expv = {op, d, s1, 5'b0, f3, f7, im};
      end
      4: begin
        op = OP_STORE;
        im = 32'(int'($urandom_range(0, 4095)) - 2048);
        expv = {op, 5'b0, s1, s2, f3, 7'b0, im};
      end
      5: begin
        op = OP_BRANCH;
        im = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
        expv = {op, 5'b0, s1, s2, f3, 7'b0, im};
      end
      6: begin
        op = OP_JAL;
        im = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
        expv = {op, d, 5'b0, 5'b0, 3'b0, 7'b0, im};
      end
      7: begin
        op = ($urandom_range(0, 1) == 1) ? OP_LUI : OP_AUIPC;
        im = $urandom & 32'hFFFF_F000;
        expv = {op, d, 5'b0, 5'b0, 3'b0, 7'b0, im};
      end
      default: begin
        op = OP_OP;
        expv = {op, d, s1, s2, f3, f7, 32'b0};
      end
    endcase
    drive(op, d, s1, s2, f3, f7, im);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] q[$];
    logic [63:0] expv;
    logic rdy;
    int acc, sent, got, gaps;
    logic prev_v, seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("rst_out_instr", 64'(out_instr), 64'(32'h0));
    check("rst_out_err",   64'(out_err),   64'(1'b0));
    check("rst_err_count", 64'(err_count), 64'(4'h0));
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1'b1));

    send_one("addi_m1",   OP_IMM,    5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    send_one("sw",        OP_STORE,  5'd0, 5'd1, 5'd2, 3'b010, 7'h00, 32'd8,         32'h0020_A423, 1'b0);
    send_one("lui",       OP_LUI,    5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send_one("jal_2048",  OP_JAL,    5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2048,      32'h0010_00EF, 1'b0);
    send_one("beq_odd",   OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5,         NOP,           1'b1);
    send_one("addi_2048", OP_IMM,    5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2048,      NOP,           1'b1);
    send_one("addi_2047", OP_IMM,    5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2047,      32'h7FF0_0093, 1'b0);
    send_one("addi_m2048",OP_IMM,    5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
    send_one("addi_m2049",OP_IMM,    5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFF_F7FF, NOP,           1'b1);
    send_one("addi_trunc",OP_IMM,    5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'h0001_0000, NOP,           1'b1);
    send_one("slli_31",   OP_IMM,    5'd1, 5'd1, 5'd0, 3'b001, 7'h00, 32'd31,        32'h01F0_9093, 1'b0);
    send_one("srai_32",   OP_IMM,    5'd1, 5'd1, 5'd0, 3'b101, 7'h20, 32'd32,        NOP,           1'b1);
    send_one("srai_neg",  OP_IMM,    5'd1, 5'd1, 5'd0, 3'b101, 7'h20, 32'hFFFF_FFFF, NOP,           1'b1);
    send_one("lw_m4",     OP_LOAD,   5'd5, 5'd2, 5'd0, 3'b010, 7'h00, 32'hFFFF_FFFC, 32'hFFC1_2283, 1'b0);
    send_one("jalr",      OP_JALR,   5'd0, 5'd1, 5'd0, 3'b000, 7'h00, 32'd0,         32'h0000_8067, 1'b0);
    send_one("sb_m2048",  OP_STORE,  5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFF_F800, 32'h8000_0023, 1'b0);
    send_one("sw_2048",   OP_STORE,  5'd0, 5'd0, 5'd0, 3'b010, 7'h00, 32'd2048,      NOP,           1'b1);
    send_one("beq_m4096", OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'hFFFF_F000, 32'h8020_8063, 1'b0);
    send_one("beq_4094",  OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'd4094,      32'h7E20_8FE3, 1'b0);
    send_one("beq_4096",  OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'd4096,      NOP,           1'b1);
    send_one("jal_min",   OP_JAL,    5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFF0_0000, 32'h8000_006F, 1'b0);
    send_one("jal_over",  OP_JAL,    5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'h0010_0000, NOP,           1'b1);
    send_one("jal_odd",   OP_JAL,    5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'd3,         NOP,           1'b1);
    send_one("lui_low",   OP_LUI,    5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h1234_5001, NOP,           1'b1);
    send_one("auipc",     OP_AUIPC,  5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFF_F000, 32'hFFFF_F017, 1'b0);
    send_one("add",       OP_OP,     5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
    send_one("sub",       OP_OP,     5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'h0000_0000, 32'h4020_81B3, 1'b0);
    send_one("bad_op",    7'h7F,     5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'h0000_0000, NOP,           1'b1);
    for (int i = 0; i < 6; i++)
      send_one("sat", 7'h7F, 5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'h0, NOP, 1'b1);

    // Backpressure: three ADDI x1 words (imm 1,2,3) offered while out_ready=0.
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        check("bp_hold_valid", 64'(out_valid), 64'(1'b1));
        check("bp_hold_instr", 64'(out_instr), 64'(32'h0010_0093));
      end
      drive(OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'(acc + 1));
      #1 rdy = in_ready;
      @(posedge clk);
      if (rdy) acc++;
    end
    @(negedge clk);
    check("bp_accepts", 64'(acc), 64'(2));
    check("bp_in_ready_full", 64'(in_ready), 64'(1'b0));
    check("bp_word0", 64'(out_instr), 64'(32'h0010_0093));
    out_ready = 1'b1;
    #1 check("bp_in_ready_release", 64'(in_ready), 64'(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_word1_valid", 64'(out_valid), 64'(1'b1));
    check("bp_word1", 64'(out_instr), 64'(32'h0020_0093));
    @(negedge clk);
    check("bp_word2_valid", 64'(out_valid), 64'(1'b1));
    check("bp_word2", 64'(out_instr), 64'(32'h0030_0093));
    @(negedge clk);
    check("bp_empty", 64'(out_valid), 64'(1'b0));

    // Streaming: 20 back-to-back random legal words.
    sent = 0; got = 0; gaps = 0; prev_v = 1'b0; seen = 1'b0;
    for (int cyc = 0; cyc < 26; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (seen && !prev_v) gaps++;
        if (q.size() > 0) begin
          expv = q.pop_front();
          check("stream_fields", decode(out_instr), expv);
          check("stream_err", 64'(out_err), 64'(1'b0));
        end else begin
          check("stream_extra", 64'(out_instr), 64'hFFFF_FFFF_FFFF_FFFF);
        end
        got++;
        seen = 1'b1;
      end
      prev_v = out_valid;
      if (sent < 20) begin
        gen_random(expv);
        q.push_back(expv);
        sent++;
        #1 check("stream_in_ready", 64'(in_ready), 64'(1'b1));
      end else begin
        in_valid = 1'b0;
      end
    end
    check("stream_count", 64'(got), 64'(20));
    check("stream_gaps", 64'(gaps), 64'(0));

    // Reset mid-operation with both stages full and err_count=3.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < 3; i++)
      send_one("pre_rst", OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'd1, NOP, 1'b1);
    out_ready = 1'b0;
    @(negedge clk) drive(OP_IMM, 5'd2, 5'd0, 5'd0, 3'b000, 7'h00, 32'd7);
    @(negedge clk) drive(OP_IMM, 5'd3, 5'd0, 5'd0, 3'b000, 7'h00, 32'd9);
    @(negedge clk) in_valid = 1'b0;
    check("full_valid", 64'(out_valid), 64'(1'b1));
    check("full_in_ready", 64'(in_ready), 64'(1'b0));
    check("full_err_count", 64'(err_count), 64'(4'd3));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'(1'b0));
    check("async_rst_err_count", 64'(err_count), 64'(4'd0));
    check("async_rst_instr", 64'(out_instr), 64'(32'h0));
    check("async_rst_in_ready", 64'(in_ready), 64'(1'b1));
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", 64'(out_valid), 64'(1'b0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RISC-V RV32I instruction encoder: accepts decoded instruction fields plus a signed 32-bit immediate, packs the immediate into the format-specific bit positions, and emits the 32-bit instruction word. It does the inverse of the core's immediate-extension stage. It sits between the self-test/boot program generator and instruction memory write port. It also flags immediates that the selected format cannot represent.

## Interface
Parameters:
- ERR_CNT_W, 16, width of saturating error counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept fields this cycle
- opcode  in  7  instr[6:0] value, from the `types` package OP_* constants
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field (R-type; shift-immediate upper bits)
- imm  in  32  signed byte-offset/immediate value as the decoder would produce it
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_err  out  1  immediate unrepresentable or opcode unsupported
- err_count  out  ERR_CNT_W  saturating count of words emitted with out_err=1

## Operation
- Encoding by opcode:
  - OP_IMM, OP_JALR, OP_LOAD: {imm[11:0], rs1, funct3, rd, opcode}. Error if imm outside [-2048, 2047].
  - OP_IMM with funct3 = 001 or 101 (shifts): {funct7, imm[4:0], rs1, funct3, rd, opcode}. Error if imm outside [0, 31].
  - OP_STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}. Error if imm outside [-2048, 2047].
  - OP_BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}. Error if imm[0]=1 or imm outside [-4096, 4094].
  - OP_JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}. Error if imm[0]=1 or imm outside [-1048576, 1048574].
  - OP_LUI, OP_AUIPC: {imm[31:12], rd, opcode}. Error if imm[11:0] ≠ 0.
  - OP (R-type): {funct7, rs2, rs1, funct3, rd, opcode}. imm ignored; never errors.
  - Any other opcode: error.
- Any error: out_instr = 32'h0000_0013 (NOP), out_err = 1. Never emit a partially packed word.
- Range checks compare imm as a full 32-bit signed value. Truncation is not a pass condition.
- Round-trip property: when out_err=0, re-decoding the immediate of out_instr returns exactly imm, and the decoder of opcode reproduces the input fields.
- err_count increments by 1 on each output handshake with out_err=1. It saturates at all-ones.

## Timing
- Two-stage pipeline:
  - S1 registers the input fields.
  - S2 registers out_instr/out_err.
- Latency: 2 cycles from input handshake to out_valid.
- Throughput: 1 word/cycle when out_ready=1.
- Handshake:
  - Transfer occurs when valid && ready on the same rising edge.
  - out_valid, out_instr and out_err hold stable while out_valid && !out_ready.
  - in_valid may not drop before acceptance. The bench enforces this; the RTL does not check it.
- Ready chain:
  - s2_ready = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_ready.
  - in_ready is combinational from out_ready. This is permitted.
- Full condition: both stages valid and out_ready=0 → in_ready=0. Exactly 2 words are buffered; none are lost or reordered.
- Simultaneous input and output handshake with both stages full: all stages advance in the same cycle.
- Reset (async assert, synchronous deassert handled upstream):
  - out_valid=0, out_instr=0, out_err=0, err_count=0.
  - Internal stage valids = 0.
  - in_ready=1 from the first cycle after deassertion.
- Reset mid-operation: in-flight words are discarded with no output. err_count clears.

## Test plan
- ADDI x1,x0,-1: opcode=0010011, rd=1, rs1=0, funct3=0, imm=32'hFFFF_FFFF → out_instr=32'hFFF0_0093, out_err=0, out_valid exactly 2 cycles after acceptance.
- SW x2,8(x1): opcode=0100011, rs1=1, rs2=2, funct3=010, imm=8 → 32'h0020_A423. LUI x5 with imm=32'h1234_5000 → 32'h1234_52B7.
- JAL x1 with imm=2048 → 32'h0010_00EF, err=0. BEQ with imm=5 → 32'h0000_0013, out_err=1, err_count 0→1. ADDI with imm=2048 → NOP, err=1, err_count=2.
- Backpressure: hold out_ready=0 for 4 cycles while offering 3 words back-to-back → in_ready drops after 2 accepts. Releasing out_ready then delivers all 3 words in input order with no gaps.
- Streaming: out_ready=1 with 20 random valid encodings → 20 consecutive out_valid cycles. A reference decoder recovers each imm/field set exactly.
- Reset: assert rst_n low with both stages full and err_count=3 → out_valid=0 and err_count=0 immediately (asynchronous). No stale word appears after release.
